// File: rtl/ddr_access_burst_ctrl_if.sv
// Handshake and data bundle between the burst controller, the DDR3 access
// buffer / scheduler, and the DDR3 native controller command port.
interface ddr_access_burst_ctrl_if #(
  parameter int ADDR_W = 26,
  parameter int LEN_W  = 8
);
  // Scheduler request side
  logic              i_req;
  logic              i_req_wr_rdn;
  logic [ADDR_W-1:0] i_req_addr;
  logic [LEN_W-1:0]  i_req_len;
  logic              o_req_rdy;

  // Access buffer side
  logic              o_ddr3_wr_rdn;
  logic              o_ddr3_ack;
  logic              o_ddr3_wr_data_rdy;
  logic [127:0]      i_ddr3_wr_data;
  logic              o_ddr3_op_done;
  logic              o_ddr3_rd_data_vld;
  logic [127:0]      o_ddr3_rd_data;

  // DDR3 native controller side
  logic              o_mem_cmd_vld;
  logic              o_mem_cmd_wr;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_cmd_rdy;
  logic              i_mem_datain_rdy;
  logic [127:0]      o_mem_wr_data;
  logic              i_mem_rd_data_vld;
  logic [127:0]      i_mem_rd_data;

  // Controller view
  modport slave (
    input  i_req, i_req_wr_rdn, i_req_addr, i_req_len,
    input  i_ddr3_wr_data,
    input  i_mem_cmd_rdy, i_mem_datain_rdy, i_mem_rd_data_vld, i_mem_rd_data,
    output o_req_rdy, o_ddr3_wr_rdn, o_ddr3_ack, o_ddr3_wr_data_rdy,
    output o_ddr3_op_done, o_ddr3_rd_data_vld, o_ddr3_rd_data,
    output o_mem_cmd_vld, o_mem_cmd_wr, o_mem_addr, o_mem_wr_data
  );

  // Buffer / scheduler / memory view
  modport master (
    output i_req, i_req_wr_rdn, i_req_addr, i_req_len,
    output i_ddr3_wr_data,
    output i_mem_cmd_rdy, i_mem_datain_rdy, i_mem_rd_data_vld, i_mem_rd_data,
    input  o_req_rdy, o_ddr3_wr_rdn, o_ddr3_ack, o_ddr3_wr_data_rdy,
    input  o_ddr3_op_done, o_ddr3_rd_data_vld, o_ddr3_rd_data,
    input  o_mem_cmd_vld, o_mem_cmd_wr, o_mem_addr, o_mem_wr_data
  );
endinterface

// File: rtl/ddr_access_burst_ctrl.sv
// Burst sequencer: accepts one request from the scheduler, acks the access
// buffer, then issues per-beat DDR3 commands and moves write/read beats.
module ddr_access_burst_ctrl #(
  parameter int ADDR_W     = 26,
  parameter int LEN_W      = 8,
  parameter int ADDR_INC   = 8,
  parameter int WR_PREFILL = 8
) (
  input logic                    i_ddr3_sclk,
  input logic                    i_rst_n,
  ddr_access_burst_ctrl_if.slave bus
);

  localparam int                CNT_W        = LEN_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_STEP    = ADDR_W'(ADDR_INC);
  localparam logic [7:0]        PREFILL_LAST = 8'(WR_PREFILL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACK,
    S_PREFILL,
    S_XFER,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0]  data_cnt_q, data_cnt_d;
  logic [7:0]        prefill_cnt_q;
  logic              rd_vld_q;
  logic [127:0]      rd_data_q;

  logic accept;
  logic cmd_vld;
  logic cmd_fire;
  logic wr_strb;
  logic rd_take;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    accept     = (state_q == S_IDLE) && bus.i_req;
    cmd_vld    = (state_q == S_XFER) && (cmd_cnt_q < len_q);
    cmd_fire   = cmd_vld && bus.i_mem_cmd_rdy;
    wr_strb    = (state_q == S_XFER) && op_wr_q && bus.i_mem_datain_rdy
                 && (data_cnt_q < len_q);
    rd_take    = (state_q == S_XFER) && !op_wr_q && bus.i_mem_rd_data_vld
                 && (data_cnt_q < len_q);
    cmd_cnt_d  = cmd_cnt_q + CNT_W'(cmd_fire);
    data_cnt_d = data_cnt_q + CNT_W'(wr_strb | rd_take);

    unique case (state_q)
      S_IDLE:    if (bus.i_req) state_d = S_SETUP;
      S_SETUP:   state_d = S_ACK;
      S_ACK:     state_d = op_wr_q ? S_PREFILL : S_XFER;
      S_PREFILL: if (prefill_cnt_q == PREFILL_LAST) state_d = S_XFER;
      // Look at the post-increment counts so the last beat and the last
      // command landing together still leave one cycle early enough.
      S_XFER:    if ((cmd_cnt_d == len_q) && (data_cnt_d == len_q)) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: state and data registers use non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_ddr3_sclk) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      op_wr_q       <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      cmd_cnt_q     <= '0;
      data_cnt_q    <= '0;
      prefill_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        op_wr_q    <= bus.i_req_wr_rdn;
        addr_q     <= bus.i_req_addr;
        len_q      <= (bus.i_req_len == '0) ? {1'b1, {LEN_W{1'b0}}}
                                            : {1'b0, bus.i_req_len};
        cmd_cnt_q  <= '0;
        data_cnt_q <= '0;
      end else begin
        if (state_q == S_DONE) op_wr_q <= 1'b0;
        if (cmd_fire) addr_q <= addr_q + ADDR_STEP;
        cmd_cnt_q  <= cmd_cnt_d;
        data_cnt_q <= data_cnt_d;
      end

      prefill_cnt_q <= (state_q == S_PREFILL) ? prefill_cnt_q + 8'd1 : 8'd0;
    end
  end

  // NOTE: the read data register is reset even though it is pure datapath,
  // because the buffer-facing bus must read as zero straight out of reset.
  always_ff @(posedge i_ddr3_sclk) begin
    if (!i_rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q <= rd_take;
      if (rd_take) rd_data_q <= bus.i_mem_rd_data;
    end
  end

  assign bus.o_req_rdy          = (state_q == S_IDLE);
  assign bus.o_ddr3_wr_rdn      = op_wr_q;
  assign bus.o_ddr3_ack         = (state_q == S_ACK);
  assign bus.o_ddr3_op_done     = (state_q == S_DONE);
  assign bus.o_ddr3_wr_data_rdy = wr_strb;
  assign bus.o_ddr3_rd_data_vld = rd_vld_q;
  assign bus.o_ddr3_rd_data     = rd_data_q;

  assign bus.o_mem_cmd_vld      = cmd_vld;
  assign bus.o_mem_cmd_wr       = cmd_vld && op_wr_q;
  assign bus.o_mem_addr         = addr_q;
  // Buffer data arrives one cycle after the pop strobe, which is exactly when
  // the DDR3 controller samples its write data, so no staging is needed.
  assign bus.o_mem_wr_data      = bus.i_ddr3_wr_data;

endmodule

// File: doc/ddr_access_burst_ctrl.md
# ddr_access_burst_ctrl

Controller-side responder for the DDR3 access buffer. It accepts one burst request at a time from the access scheduler and sequences per-beat commands to the DDR3 native controller. Toward the access buffer it drives the ack, write-data-ready, op-done and read-data-valid handshakes, and it passes 128-bit write and read data between the buffer and the DDR3 controller.

## Interface
Parameters:
- ADDR_W, 26: DDR3 command address width.
- LEN_W, 8: burst length field width. Length 0 encodes 2^LEN_W beats.
- ADDR_INC, 8: address increment per 128-bit beat.
- WR_PREFILL, 8: cycles waited after ack before the first write command, so the buffer FIFO can fill. Legal range 1..255.

Ports:
- i_ddr3_sclk  in  1  clock. Single clock domain.
- i_rst_n  in  1  reset. Synchronous, active-low.
- i_req  in  1  burst request.
- i_req_wr_rdn  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_W  start address.
- i_req_len  in  LEN_W  beats.
- o_req_rdy  out  1  high in IDLE only.
- o_ddr3_wr_rdn  out  1  operation direction, held from SETUP until IDLE.
- o_ddr3_ack  out  1  one-cycle accept pulse.
- o_ddr3_wr_data_rdy  out  1  write-data pop strobe.
- i_ddr3_wr_data  in  128  write data, valid 1 cycle after o_ddr3_wr_data_rdy.
- o_ddr3_op_done  out  1  one-cycle completion pulse.
- o_ddr3_rd_data_vld  out  1  read beat valid.
- o_ddr3_rd_data  out  128  read data.
- o_mem_cmd_vld  out  1  command valid.
- o_mem_cmd_wr  out  1  command type, 1 = write.
- o_mem_addr  out  ADDR_W  command address.
- i_mem_cmd_rdy  in  1  controller accepts command.
- i_mem_datain_rdy  in  1  controller requests a write beat.
- o_mem_wr_data  out  128  equals i_ddr3_wr_data (combinational pass-through).
- i_mem_rd_data_vld  in  1  read beat from controller.
- i_mem_rd_data  in  128  read data from controller.

## Operation
States: IDLE, SETUP, ACK, PREFILL, XFER, DONE.
- **IDLE:** o_req_rdy=1. On i_req=1, latch direction, address and length (0 → 2^LEN_W), drive o_ddr3_wr_rdn, go to SETUP.
- **SETUP:** 1 cycle. Gives the direction signal one stable cycle before ack, because the buffer registers it. Go to ACK.
- **ACK:** o_ddr3_ack=1 for 1 cycle. Write → PREFILL; read → XFER.
- **PREFILL:** counts WR_PREFILL cycles, then goes to XFER.
- **XFER:**
  - Command counter cmd_cnt: o_mem_cmd_vld=1 while cmd_cnt<len. cmd_cnt increments on o_mem_cmd_vld & i_mem_cmd_rdy.
  - o_mem_addr = base + cmd_cnt*ADDR_INC, modulo 2^ADDR_W (wrap allowed).
  - Data counter data_cnt:
    - Write: o_ddr3_wr_data_rdy = i_mem_datain_rdy & (data_cnt<len), combinational. data_cnt increments on each such strobe.
    - Read: data_cnt increments on each i_mem_rd_data_vld.
  - Exit to DONE when cmd_cnt==len and data_cnt==len, including when both reach len in the same cycle.
- **DONE:** o_ddr3_op_done=1 for 1 cycle, o_ddr3_wr_rdn cleared, go to IDLE.

Boundary rules:
- i_req is ignored outside IDLE.
- i_mem_datain_rdy is ignored unless state is XFER, the operation is a write, and data_cnt<len.
- i_mem_rd_data_vld is ignored (not forwarded) unless state is XFER, the operation is a read, and data_cnt<len.
- Counters are LEN_W+1 bits wide, so 2^LEN_W beats are representable.
- Reset asserted mid-operation: next edge returns to IDLE, counters clear, all outputs go to 0, and no op_done is emitted.

## Timing
- Reset values: every output is 0, except o_req_rdy=1 (IDLE).
- Request in cycle T gives SETUP at T+1, ack at T+2.
- Write: first o_mem_cmd_vld at T+3+WR_PREFILL.
- Read: first o_mem_cmd_vld at T+3.
- o_mem_cmd_vld and o_mem_addr stay stable until i_mem_cmd_rdy.
- Read path: o_ddr3_rd_data_vld and o_ddr3_rd_data are registered, 1 cycle after i_mem_rd_data_vld and i_mem_rd_data.
- Write path: i_ddr3_wr_data is expected 1 cycle after o_ddr3_wr_data_rdy. The DDR3 controller samples o_mem_wr_data 1 cycle after its datain_rdy.
- op_done occurs 1 cycle after the final counter reaches len. The next request can be accepted the cycle after op_done (IDLE).

## Test plan
- **Write, len=4, addr=0x100, cmd_rdy=1, datain_rdy pulsed 4×:**
  - ack at T+2.
  - Commands at T+11..T+14 with addresses 0x100/0x108/0x110/0x118.
  - 4 wr_data_rdy strobes; o_mem_wr_data tracks i_ddr3_wr_data.
  - op_done 1 cycle after the 4th strobe.
- **Read, len=3, rd_data_vld 3× with data A, B, C, cmd_rdy toggling 1/0:**
  - 3 commands issued, each held while cmd_rdy=0.
  - o_ddr3_rd_data_vld 1 cycle after each input beat, carrying A, B, C.
  - op_done after C.
- **len=0 write:** exactly 256 commands and 256 wr_data_rdy strobes, then one op_done.
- **Address wrap, ADDR_W=26, addr=0x3FFFFF8, len=2:** addresses 0x3FFFFF8 then 0x0000000.
- **Reset asserted during XFER of an 8-beat read after 3 beats:**
  - Next cycle: all outputs 0, o_req_rdy=1, no op_done.
  - A new request is then serviced normally.
- **Spurious inputs in IDLE (rd_data_vld and datain_rdy high for 5 cycles):** no o_ddr3_rd_data_vld, no wr_data_rdy, no ack.
